// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time over valid/ready, serviced after a
// fixed LATENCY, answered over a second valid/ready handshake. Byte-addressed, little-endian.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  we_q, we_d;
    logic                  byte_q, byte_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic [7:0]            mem [DEPTH];

    logic                  accept;
    logic                  access;
    logic                  misaligned;
    logic                  do_write;
    logic [ADDR_WIDTH-1:0] a0, a1, a2, a3;
    logic [31:0]           load_word;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign accept     = req_valid && (state_q == IDLE);
    assign access     = (state_q == WAIT) && (cnt_q == 4'd0);
    assign misaligned = !byte_q && (addr_q[1:0] != 2'b00);
    assign do_write   = access && we_q && !misaligned;

    // Word lanes are only used when aligned, so the upper bits never need to carry.
    assign a0 = addr_q;
    assign a1 = {addr_q[ADDR_WIDTH-1:2], 2'b01};
    assign a2 = {addr_q[ADDR_WIDTH-1:2], 2'b10};
    assign a3 = {addr_q[ADDR_WIDTH-1:2], 2'b11};

    assign load_word = {mem[a3], mem[a2], mem[a1], mem[a0]};

    always_comb begin
        we_d    = we_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = req_we;
            byte_d  = req_byte;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    if (misaligned) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else if (we_q) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b0;
                    end else begin
                        rdata_d = byte_q ? {24'd0, mem[a0]} : load_word;
                        err_d   = 1'b0;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Captured request fields are pure data and need no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        byte_q  <= byte_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    // The array is written only on the WAIT-to-RESP edge; reset holds state in IDLE so no write leaks.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[a0] <= wdata_q[7:0];
            if (!byte_q) begin
                mem[a1] <= wdata_q[15:8];
                mem[a2] <= wdata_q[23:16];
                mem[a3] <= wdata_q[31:24];
            end
        end
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store path, i.e. the far end of the data-memory interface.
- Accepts one request at a time over a valid/ready handshake and services it after a fixed programmable latency.
- Returns read data, or a write acknowledge, over a second valid/ready handshake.
- Supports word and byte accesses. Lets the core move from a zero-latency memory to a multi-cycle one.

Parameters:
- ADDR_WIDTH, 12, byte-address width; storage is 2**ADDR_WIDTH bytes.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_byte  input  1  1 = byte access, 0 = word access.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data; byte stores use bits [7:0].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  misaligned word access.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; counter clears.
  - resp_valid=0, resp_rdata=0, resp_err=0. req_ready=1 once rst is high.
  - Storage array is not reset.
- States: IDLE, WAIT, RESP.
- req_ready is high only in IDLE. Only one request is outstanding at a time.
- IDLE:
  - On req_valid & req_ready at a rising edge, capture we/byte/addr/wdata into internal registers.
  - Load the counter with LATENCY-1 and go to WAIT.
  - Input changes after acceptance have no effect.
- WAIT:
  - If counter != 0, decrement it.
  - If counter == 0, perform the access at that edge and go to RESP with resp_valid=1.
  - Net latency: accepted at edge t0, so resp_valid is high after edge t0+LATENCY.
- Access rules (little-endian):
  - Word store: bytes addr..addr+3 <= wdata[7:0]..wdata[31:24].
  - Byte store: byte addr <= wdata[7:0].
  - Word load: rdata = {mem[addr+3], mem[addr+2], mem[addr+1], mem[addr]}.
  - Byte load: rdata = {24'b0, mem[addr]} (zero-extended).
  - Stores return rdata=0, err=0.
  - Misaligned word (addr[1:0] != 0): no write occurs, rdata=0, err=1.
  - Byte accesses are never misaligned.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready at an edge.
  - At that edge: return to IDLE, drop resp_valid, clear rdata and err.
  - No same-cycle re-accept; req_ready rises the cycle after the response handshake.
- resp_ready high before resp_valid is legal and causes the handshake on the first RESP cycle.
- Reset mid-operation:
  - An in-flight request is dropped.
  - A store whose access edge has not yet occurred is not written.
  - A store already written stays written.
- Read-after-write returns the new data, because accesses are strictly serialized.
- Memory is written only at the WAIT-to-RESP transition edge.

Test Plan:
- Word store then load, LATENCY=2: store addr 0x010, wdata 0xDEADBEEF; resp_valid rises 2 cycles after acceptance with rdata=0, err=0. Then load 0x010 returns rdata=0xDEADBEEF; req_ready is low for the entire WAIT/RESP period.
- Byte access: word store 0x11223344 at 0x020, then byte store 0xAA to 0x022. Word load at 0x020 returns 0x11AA3344; byte load at 0x023 returns 0x00000011.
- Misaligned word: word store 0xFFFFFFFF to 0x031 gives err=1, rdata=0. Word load at 0x030 still returns its prior value; word load at 0x033 gives err=1.
- Backpressure: hold resp_ready low 5 cycles after resp_valid. resp_valid, rdata and err stay constant and req_ready stays low. After resp_ready goes high, resp_valid drops at the next edge and req_ready is high the cycle after.
- Reset mid-operation: accept word store 0x12345678 to 0x040 and pulse rst low during WAIT. Outputs reset immediately and req_ready=1 after release; a load of 0x040 returns the pre-store value.
- Latency sweep: LATENCY=1 gives resp_valid one edge after acceptance; LATENCY=15 gives 15 edges. Back-to-back requests with resp_ready tied high complete one per LATENCY+2 cycles.
